uart_pattern_mon: RTL
=====================

Name: uart_pattern_mon

Overview:
- Parametrised successor to the testbench UART PASS/FAIL monitor.
- Watches the UART TX byte stream and keeps a sliding window of the last PAT_LEN bytes.
- Matches the window against a configurable PASS string and FAIL string, with optional case folding, and adds an idle-timeout watchdog.
- Verdicts are sticky status outputs plus a one-cycle done pulse, so the bench top decides when to call $finish. The block is synthesizable RTL and sits beside the SoC UART in the testbench.

Parameters:
- PAT_LEN, 4, pattern length in bytes; legal range 1..8.
- PASS_PAT, "PASS", PASS pattern, PAT_LEN*8 bits, first character in the MSByte.
- FAIL_PAT, "FAIL", FAIL pattern, same format as PASS_PAT.
- TIMEOUT_CYC, 0, idle cycles without an accepted byte before timeout; 0 disables the watchdog.
- CASE_INSENS, 0, 1 = fold a-z to A-Z on both the window and the patterns before compare.
- CNT_W, 32, width of byte_cnt and of the idle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  monitor enable; when low, bytes are ignored and the idle counter is frozen
- clr  in  1  synchronous soft clear of the verdict, window and counters
- valid_1  in  1  byte qualifier 1
- valid_2  in  1  byte qualifier 2
- data  in  8  UART byte
- pass  out  1  sticky PASS verdict
- fail  out  1  sticky FAIL verdict
- timeout  out  1  sticky watchdog verdict
- done  out  1  one-cycle pulse when any verdict is first reached
- byte_cnt  out  CNT_W  count of accepted bytes since reset or clear

Behaviour:
- Reset: on rst=1 at a clk edge:
  - state=MON; window cleared; fill=0; idle=0; byte_cnt=0.
  - pass, fail, timeout and done are all 0.
- Accept condition: accept = en & valid_1 & valid_2 & (state==MON) & !clr.
- Window update on accept, at edge E0:
  - Shift in: window = {window[PAT_LEN-2:0], data}. The newest byte is in the LSByte, so the oldest is compared against the pattern MSByte.
  - fill saturates at PAT_LEN.
  - byte_cnt increments, wrapping modulo 2^CNT_W.
  - idle resets to 0.
- Match rule: match_x = (fill==PAT_LEN) & (fold(window)==fold(PAT_x)). fold is the identity when CASE_INSENS=0.
  - The fill gate prevents false matches on the zero-initialised window.
- Verdict latency: the compare is combinational on the registered window, and the verdict registers at the next edge E1.
  - pass/fail/done are high for the first time in the cycle after E1: one cycle after the completing byte is sampled.
- State machine states: MON, PASS, FAIL, TOUT.
  - MON -> FAIL if match_fail. FAIL has priority when both match, e.g. identical patterns.
  - MON -> PASS if match_pass & !match_fail.
  - MON -> TOUT if TIMEOUT_CYC!=0 & idle==TIMEOUT_CYC-1 & !accept & en.
  - PASS/FAIL/TOUT are terminal. They hold until rst or clr, and bytes in these states are not accepted and not counted.
- Outputs:
  - pass = (state==PASS), fail = (state==FAIL), timeout = (state==TOUT), all registered.
  - done is high for exactly one cycle, on the MON -> terminal transition.
- Idle counter: in MON with en=1 and no accept, idle increments and saturates; with en=0 it holds.
  - Timeout is reached after exactly TIMEOUT_CYC consecutive enabled idle cycles.
- Clear: clr=1 at an edge behaves like rst for all state and outputs. clr wins over a coincident byte, which is dropped.
- Reset or clear mid-pattern: the partial window is discarded. A pattern must be received entirely after the clear to match.
- Overlap: the window slides, so matching is overlap-tolerant, e.g. "PPASS" matches.
- Sim-only display: in PASS/FAIL/TOUT entry, print "<VERDICT> Detected on UART" inside translate_off.

Decomposition:
- Package uart_mon_pkg:
  - mon_state_e enum {MON, PASS, FAIL, TOUT}.
  - function to_upper_byte, plus a fold function over a PAT_LEN byte vector.
  - localparam MAX_PAT_LEN=8.
- Sub-module uart_byte_window: parametrised shift register with saturating fill count.
  - Inputs: clk, rst, clr, shift, data.
  - Outputs: window, full.
  - The top owns compare, FSM, watchdog and counters.

Test Plan:
- Exact PASS: send 'P','A','S','S' on consecutive cycles -> pass=1 one cycle after the last byte, done pulses once, byte_cnt=4, fail=0.
- FAIL priority with filler: send "xxFAIL", then "PASS" -> fail=1 after the 6th byte; later bytes ignored, byte_cnt=6, pass stays 0.
- Qualifier/enable gating:
  - bytes with valid_2=0 are not counted;
  - en=0 during "PASS" -> no verdict, byte_cnt=0;
  - en=1 resend -> pass.
- Case folding: CASE_INSENS=1, send "pAsS" -> pass=1. With CASE_INSENS=0, the same stream leaves state MON.
- Watchdog: TIMEOUT_CYC=10, one byte, then 10 idle enabled cycles -> timeout=1 on cycle 10, done pulse. A byte at idle cycle 9 restarts the count with no timeout.
- Clear mid-pattern: send "PAS", clr and 'S' in the same cycle, then "S" -> no match, byte_cnt=1. Then "PASS" -> pass=1. PAT_LEN=1 with PASS_PAT="!": a single '!' -> pass.

Source files
------------

// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the UART pattern monitor.
// Holds the verdict state encoding and the ASCII case-folding helpers.
package uart_mon_pkg;

   localparam int MAX_PAT_LEN = 8;

   typedef enum logic [1:0] {
      MON  = 2'd0,
      PASS = 2'd1,
      FAIL = 2'd2,
      TOUT = 2'd3
   } mon_state_e;

   function automatic logic [7:0] to_upper_byte(input logic [7:0] b);
      logic [7:0] r;
      if ((b >= 8'h61) && (b <= 8'h7A)) begin
         r = b - 8'h20;
      end else begin
         r = b;
      end
      return r;
   endfunction

   // Unused upper bytes are zero, which folds to zero, so narrower patterns fold correctly.
   function automatic logic [MAX_PAT_LEN*8-1:0] fold_bytes(input logic [MAX_PAT_LEN*8-1:0] v);
      logic [MAX_PAT_LEN*8-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_PAT_LEN; i++) begin
         r[i*8 +: 8] = to_upper_byte(v[i*8 +: 8]);
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_byte_window.sv
// Sliding window of the last PAT_LEN bytes, newest byte in the LSByte.
// The full flag saturates once PAT_LEN bytes have been shifted in since reset or clear.
module uart_byte_window #(
   parameter int PAT_LEN = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift,
   input  logic [7:0]         data,
   output logic [PAT_LEN*8-1:0] window,
   output logic               full
);

   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

   logic [PAT_LEN*8-1:0] window_r;
   logic [PAT_LEN*8-1:0] next_win_s;
   logic [FILL_W-1:0]    fill_r;

   generate
      if (PAT_LEN == 1) begin : g_single
         assign next_win_s = data;
      end else begin : g_multi
         assign next_win_s = {window_r[(PAT_LEN-1)*8-1:0], data};
      end
   endgenerate

   // Shift register and saturating fill counter
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         window_r <= '0;
         fill_r   <= '0;
      end else if (shift) begin
         window_r <= next_win_s;
         if (fill_r != FILL_MAX) begin
            fill_r <= fill_r + FILL_W'(1);
         end
      end
   end

   assign window = window_r;
   assign full   = (fill_r == FILL_MAX);

endmodule

// File: rtl/uart_pattern_mon.sv
// UART TX stream monitor: matches the last PAT_LEN bytes against PASS/FAIL strings
// and runs an idle watchdog; verdicts are sticky until rst or clr.
module uart_pattern_mon
   import uart_mon_pkg::*;
#(
   parameter int                  PAT_LEN     = 4,
   parameter logic [PAT_LEN*8-1:0] PASS_PAT    = "PASS",
   parameter logic [PAT_LEN*8-1:0] FAIL_PAT    = "FAIL",
   parameter int                  TIMEOUT_CYC = 0,
   parameter int                  CASE_INSENS = 0,
   parameter int                  CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             valid_1,
   input  logic             valid_2,
   input  logic [7:0]       data,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic             done,
   output logic [CNT_W-1:0] byte_cnt
);

   localparam int CMP_W = MAX_PAT_LEN * 8;
   localparam logic [CMP_W-1:0] PASS_EXT  = CMP_W'(PASS_PAT);
   localparam logic [CMP_W-1:0] FAIL_EXT  = CMP_W'(FAIL_PAT);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

   mon_state_e state_r;
   logic             pass_r;
   logic             fail_r;
   logic             timeout_r;
   logic             done_r;
   logic [CNT_W-1:0] byte_cnt_r;
   logic [CNT_W-1:0] idle_r;

   logic [PAT_LEN*8-1:0] window_s;
   logic                 full_s;
   logic                 accept_s;
   logic                 match_pass_s;
   logic                 match_fail_s;
   logic                 idle_hit_s;
   logic [CMP_W-1:0]     win_cmp_s;
   logic [CMP_W-1:0]     pass_cmp_s;
   logic [CMP_W-1:0]     fail_cmp_s;

   assign accept_s = en & valid_1 & valid_2 & (state_r == MON) & ~clr;

   uart_byte_window #(
      .PAT_LEN (PAT_LEN)
   ) u_window (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .shift  (accept_s),
      .data   (data),
      .window (window_s),
      .full   (full_s)
   );

   // Optional case folding of window and patterns ahead of the compare
   always_comb begin
      win_cmp_s  = CMP_W'(window_s);
      pass_cmp_s = PASS_EXT;
      fail_cmp_s = FAIL_EXT;
      if (CASE_INSENS != 0) begin
         win_cmp_s  = fold_bytes(CMP_W'(window_s));
         pass_cmp_s = fold_bytes(PASS_EXT);
         fail_cmp_s = fold_bytes(FAIL_EXT);
      end else begin
         win_cmp_s  = CMP_W'(window_s);
         pass_cmp_s = PASS_EXT;
         fail_cmp_s = FAIL_EXT;
      end
   end

   // The full gate keeps the zero-initialised window from matching a NUL pattern.
   assign match_pass_s = full_s & (win_cmp_s == pass_cmp_s);
   assign match_fail_s = full_s & (win_cmp_s == fail_cmp_s);
   assign idle_hit_s   = (TIMEOUT_CYC != 0) & (idle_r == IDLE_LAST) & ~accept_s & en;

   // Verdict FSM with byte and idle counters; all outputs registered
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_r    <= MON;
         pass_r     <= 1'b0;
         fail_r     <= 1'b0;
         timeout_r  <= 1'b0;
         done_r     <= 1'b0;
         byte_cnt_r <= '0;
         idle_r     <= '0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            MON: begin
               if (accept_s) begin
                  byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                  idle_r     <= '0;
               end else if (en && (idle_r != {CNT_W{1'b1}})) begin
                  idle_r <= idle_r + CNT_W'(1);
               end
               if (match_fail_s) begin
                  state_r <= FAIL;
                  fail_r  <= 1'b1;
                  done_r  <= 1'b1;
               end else if (match_pass_s) begin
                  state_r <= PASS;
                  pass_r  <= 1'b1;
                  done_r  <= 1'b1;
               end else if (idle_hit_s) begin
                  state_r   <= TOUT;
                  timeout_r <= 1'b1;
                  done_r    <= 1'b1;
               end
            end
            PASS, FAIL, TOUT: begin
               state_r <= state_r;
            end
            default: begin
               state_r   <= MON;
               pass_r    <= 1'b0;
               fail_r    <= 1'b0;
               timeout_r <= 1'b0;
            end
         endcase
      end
   end

   assign pass     = pass_r;
   assign fail     = fail_r;
   assign timeout  = timeout_r;
   assign done     = done_r;
   assign byte_cnt = byte_cnt_r;

endmodule
